// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM generator.
// Default widths and power-on settings live here so top and sub-modules agree.
package pwm_pkg;
  localparam int DUTY_W        = 4;
  localparam int PERIOD_DEF    = 10;
  localparam int DUTY_INIT_DEF = 5;
  localparam int DEBOUNCE_DEF  = 4;

  typedef logic [DUTY_W-1:0] duty_t;
endpackage

// File: rtl/switch_cond.sv
// Switch conditioner: 2-flop synchronizer, optional debouncer (PWM_DEBOUNCE_EN),
// and a one-cycle rising-edge pulse on the conditioned level.
module switch_cond
  import pwm_pkg::*;
`ifdef PWM_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic pulse_o
);

  logic       sync1_q, sync2_q;
  logic       level;
  logic       prev_q;
  logic [1:0] start_q;
  logic       armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] stable_cnt_q;
  logic          filt_q;

  // Filtered level follows the input only after it has differed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt_q <= '0;
      filt_q       <= 1'b0;
    end else if (sync2_q == filt_q) begin
      stable_cnt_q <= '0;
    end else if (stable_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_cnt_q <= '0;
      filt_q       <= sync2_q;
    end else begin
      stable_cnt_q <= stable_cnt_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // Arm only after a post-reset low has been seen, so a switch held through reset gives no step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      start_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= level;
      start_q <= {start_q[0], 1'b1};
      if (start_q[1] && !sync2_q) armed_q <= 1'b1;
    end
  end

  assign pulse_o = level & ~prev_q & armed_q;

endmodule

// File: rtl/pwm_generator.sv
// Fixed-period PWM with duty stepped in 1/PERIOD increments by two switches.
// Define PWM_DEBOUNCE_EN to insert a debouncer into each switch path.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int PERIOD    = PERIOD_DEF,
  parameter int DUTY_INIT = DUTY_INIT_DEF
`ifdef PWM_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
`endif
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              swt_increase,
  input  logic              swt_decrease,
  output logic              PWM_OUT,
  output logic [DUTY_W-1:0] DUTY_CYCLE
);

  localparam duty_t PERIOD_D   = duty_t'(PERIOD);
  localparam duty_t CNT_LAST   = duty_t'(PERIOD - 1);
  localparam duty_t DUTY_RST   = duty_t'(DUTY_INIT);

  logic [1:0] sw_raw;
  logic [1:0] sw_pulse;
  logic       inc_p, dec_p;

  assign sw_raw = {swt_decrease, swt_increase};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sw
    switch_cond
`ifdef PWM_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_i    (sw_raw[gi]),
        .pulse_o (sw_pulse[gi])
      );
  end

  assign inc_p = sw_pulse[0];
  assign dec_p = sw_pulse[1];

  duty_t cnt_q, cnt_d;
  duty_t duty_reg_q, duty_reg_d;
  duty_t duty_act_q;
  logic  pwm_q;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    duty_reg_d = duty_reg_q;
    if (inc_p && !dec_p && duty_reg_q < PERIOD_D) begin
      duty_reg_d = duty_reg_q + 1'b1;
    end else if (dec_p && !inc_p && duty_reg_q != '0) begin
      duty_reg_d = duty_reg_q - 1'b1;
    end
  end

  // Active duty is only reloaded at the period boundary so no runt pulses appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      duty_reg_q <= DUTY_RST;
      duty_act_q <= DUTY_RST;
      pwm_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      duty_reg_q <= duty_reg_d;
      if (cnt_q == CNT_LAST) duty_act_q <= duty_reg_q;
      pwm_q      <= (cnt_q < duty_act_q);
    end
  end

  assign PWM_OUT    = pwm_q;
  assign DUTY_CYCLE = duty_reg_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: stimulus queues expected duty steps,
// a negedge monitor pops and checks each DUTY_CYCLE change (value and cycle).
module tb_pwm_generator;

  localparam int PERIOD    = 10;
  localparam int DUTY_INIT = 5;
`ifdef PWM_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       swt_increase = 1'b0;
  logic       swt_decrease = 1'b0;
  logic       pwm;
  logic [3:0] duty;

  always #5 clk = ~clk;

  pwm_generator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .swt_increase (swt_increase),
    .swt_decrease (swt_decrease),
    .PWM_OUT      (pwm),
    .DUTY_CYCLE   (duty)
  );

  typedef struct {
    int val;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   since_rst = 0;
  int   last_duty = DUTY_INIT;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) since_rst <= 0;
    else        since_rst <= since_rst + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUTY_CYCLE change outside reset must match the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_duty = duty;
    end else if (duty != last_duty) begin
      if (sb.size() == 0) begin
        check("unexpected_duty_change", duty, last_duty);
      end else begin
        mon_e = sb.pop_front();
        check("duty_value", duty, mon_e.val);
        check("duty_step_cycle", cyc, mon_e.at);
        $display("[TB] duty %0d -> %0d at cycle %0d", last_duty, duty, cyc);
      end
      last_duty = duty;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_pwm", pwm, 0);
    check("reset_duty", duty, DUTY_INIT);
    wait_cycles(3);
    rst_n = 1'b1;
  endtask

  // One switch pulse; exp_val < 0 means no step is expected.
  task automatic pulse(input bit inc, input int hi, input int lo, input int exp_val);
    exp_t e;
    if (inc) swt_increase = 1'b1;
    else     swt_decrease = 1'b1;
    if (exp_val >= 0) begin
      e.val = exp_val;
      e.at  = cyc + LAT;
      sb.push_back(e);
    end
    wait_cycles(hi);
    swt_increase = 1'b0;
    swt_decrease = 1'b0;
    wait_cycles(lo);
  endtask

  task automatic check_pwm_highs(input string name, input int exp);
    int highs;
    highs = 0;
    wait_cycles(2 * PERIOD + 5);
    for (int k = 0; k < PERIOD; k++) begin
      if (pwm) highs++;
      @(negedge clk);
    end
    check(name, highs, exp);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   exp_pwm;
    int   act;

    // Phase 1: power-on reset and the first two periods
    #1 rst_n = 1'b0;
    wait_cycles(3);
    check("reset_pwm", pwm, 0);
    check("reset_duty", duty, DUTY_INIT);
    rst_n = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      exp_pwm = (since_rst == 0) ? 0 : int'(((since_rst - 1) % PERIOD) < DUTY_INIT);
      check("first_periods_pwm", pwm, exp_pwm);
      @(negedge clk);
    end
    check_pwm_highs("pwm_highs_duty5", 5);

    // Phase 2: six increase pulses, saturating at PERIOD
    for (int i = 0; i < 6; i++) pulse(1'b1, 10, 10, (i < 5) ? 6 + i : -1);
    check("drain_after_inc", sb.size(), 0);
    check("duty_saturate_high", duty, 10);
    check_pwm_highs("pwm_highs_duty10", 10);

    // Phase 3: eleven decrease pulses, saturating at 0
    for (int i = 0; i < 11; i++) pulse(1'b0, 10, 10, (i < 10) ? 9 - i : -1);
    check("drain_after_dec", sb.size(), 0);
    check("duty_saturate_low", duty, 0);
    check_pwm_highs("pwm_highs_duty0", 0);

    // Phase 4: increase held for 100 cycles gives one step
    do_reset();
    wait_cycles(5);
    pulse(1'b1, 100, 10, 6);
    check("drain_after_hold", sb.size(), 0);
    check("duty_after_hold", duty, 6);

    // Phase 5: both switches rising together
    do_reset();
    wait_cycles(5);
    swt_increase = 1'b1;
    swt_decrease = 1'b1;
    wait_cycles(20);
    swt_increase = 1'b0;
    swt_decrease = 1'b0;
    wait_cycles(10);
    check("duty_after_both", duty, DUTY_INIT);

    // Phase 6: duty_reg changes at cnt==3; current period keeps old high time
    do_reset();
    for (int g = 0; g < 50 && since_rst != 13 - LAT; g++) @(negedge clk);
    check("align_mid_period", since_rst, 13 - LAT);
    swt_increase = 1'b1;
    e.val = 6;
    e.at  = cyc + LAT;
    sb.push_back(e);
    for (int g = 0; g < 60 && since_rst <= 40; g++) begin
      if (since_rst >= 11) begin
        act     = (since_rst <= 20) ? 5 : 6;
        exp_pwm = int'(((since_rst - 1) % PERIOD) < act);
        check("mid_period_pwm", pwm, exp_pwm);
      end
      @(negedge clk);
    end
    swt_increase = 1'b0;
    check("drain_mid_period", sb.size(), 0);

    // Phase 7: asynchronous reset while PWM_OUT is high
    for (int g = 0; g < 20 && (since_rst % PERIOD) != 2; g++) @(negedge clk);
    check("pre_reset_pwm", pwm, 1);
    check("pre_reset_duty", duty, 6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", pwm, 0);
    check("async_reset_duty", duty, DUTY_INIT);
    wait_cycles(3);
    rst_n = 1'b1;

    // Phase 8: two-cycle glitch on increase
    wait_cycles(5);
`ifdef PWM_DEBOUNCE_EN
    pulse(1'b1, 2, 20, -1);
    check("duty_after_glitch", duty, DUTY_INIT);
`else
    pulse(1'b1, 2, 20, 6);
    check("duty_after_glitch", duty, 6);
`endif

    check("final_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
